// File: rtl/r_backward_arbiter_if.sv
// R-channel beat link: packed beat, valid, ready.
// "master" drives a beat downstream; "slave" receives one.
interface r_backward_arbiter_if #(
  parameter int unsigned DW = 79
);
  logic [DW-1:0] DATA;
  logic          VALID;
  logic          READY;

  modport master (output DATA, output VALID, input READY);
  modport slave  (input DATA, input VALID, output READY);
endinterface

// File: rtl/r_backward_arbiter.sv
// Four-to-one R-beat arbiter.
// Round-robin between bursts, locked to one port until its RLAST beat passes.
// A single output register gives one cycle of latency at full throughput.
module r_backward_arbiter #(
  parameter int unsigned DW = 79
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  r_backward_arbiter_if.slave   s0,
  r_backward_arbiter_if.slave   s1,
  r_backward_arbiter_if.slave   s2,
  r_backward_arbiter_if.slave   s3,
  r_backward_arbiter_if.master  m
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    owner;
  logic [1:0]    last_grant;
  logic [1:0]    sel;
  logic [1:0]    cand;
  logic          sel_ok;
  logic          load_en;
  logic          accept;
  logic          acc_last;
  logic [3:0]    vld;
  logic [3:0]    rdy;
  logic [DW-1:0] din [4];
  logic [DW-1:0] out_data;
  logic          out_valid;

  assign vld    = {s3.VALID, s2.VALID, s1.VALID, s0.VALID};
  assign din[0] = s0.DATA;
  assign din[1] = s1.DATA;
  assign din[2] = s2.DATA;
  assign din[3] = s3.DATA;

  // Output register can take a beat when empty or draining; never in reset.
  assign load_en  = ARESETn & (~out_valid | m.READY);
  assign accept   = |(rdy & vld);
  assign acc_last = din[sel][0];

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: lock on a non-last beat, release on the owner's last beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !acc_last) state_nxt = LOCKED;
      LOCKED:  if (accept &&  acc_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: port selection and the one-hot ready vector.
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    cand   = '0;
    rdy    = '0;
    if (state == LOCKED) begin
      sel    = owner;
      sel_ok = 1'b1;
    end else begin
      // Scan starts one past the last grant; 2-bit add wraps 3 -> 0.
      for (int unsigned k = 1; k <= 4; k++) begin
        cand = last_grant + 2'(k);
        if (!sel_ok && vld[cand]) begin
          sel    = cand;
          sel_ok = 1'b1;
        end
      end
    end
    if (sel_ok && load_en) rdy[sel] = 1'b1;
  end

  // Burst owner and round-robin pointer.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      owner      <= '0;
      last_grant <= 2'd3;
    end else if (accept) begin
      if (acc_last)           last_grant <= sel;
      else if (state == IDLE) owner      <= sel;
    end
  end

  // Output register: replaced on accept, cleared when drained with no refill.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load_en) begin
      out_valid <= accept;
      if (accept) out_data <= din[sel];
    end
  end

  assign m.DATA   = out_data;
  assign m.VALID  = out_valid;
  assign s0.READY = rdy[0];
  assign s1.READY = rdy[1];
  assign s2.READY = rdy[2];
  assign s3.READY = rdy[3];

endmodule

// File: tb/tb_r_backward_arbiter.sv
// Scoreboard bench for r_backward_arbiter with a behavioural arbitration model.
module tb_r_backward_arbiter;
  localparam int unsigned DW = 79;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;

  r_backward_arbiter_if #(.DW(DW)) s0 ();
  r_backward_arbiter_if #(.DW(DW)) s1 ();
  r_backward_arbiter_if #(.DW(DW)) s2 ();
  r_backward_arbiter_if #(.DW(DW)) s3 ();
  r_backward_arbiter_if #(.DW(DW)) m ();

  r_backward_arbiter #(.DW(DW)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s0      (s0),
    .s1      (s1),
    .s2      (s2),
    .s3      (s3),
    .m       (m)
  );

  always #5 ACLK = ~ACLK;

  logic [3:0]    tv;
  logic [DW-1:0] td [4];
  logic          rdy_in;
  logic [3:0]    dr;

  assign s0.VALID = tv[0];
  assign s1.VALID = tv[1];
  assign s2.VALID = tv[2];
  assign s3.VALID = tv[3];
  assign s0.DATA  = td[0];
  assign s1.DATA  = td[1];
  assign s2.DATA  = td[2];
  assign s3.DATA  = td[3];
  assign m.READY  = rdy_in;
  assign dr = {s3.READY, s2.READY, s1.READY, s0.READY};

  int compared = 0;
  int mismatched = 0;

  // Pending beats per port (whole bursts) and beats expected on the output.
  logic [DW-1:0] pq [4][$];
  logic [DW-1:0] sb [$];

  // Reference model state.
  bit locked = 1'b0;
  int owner = 0;
  int lg = 3;
  bit full = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat(input bit last);
    logic [95:0] r;
    logic [DW-1:0] b;
    r = {$urandom, $urandom, $urandom};
    b = r[DW-1:0];
    b[0] = last;
    return b;
  endfunction

  task automatic push_burst(input int p, input int len);
    for (int j = 0; j < len; j++) pq[p].push_back(rand_beat(j == len - 1));
  endtask

  // One bus cycle: entered and left at posedge+1.
  task automatic step(input int vp, input int rp, input int newp);
    int sel;
    bit have;
    bit le;
    bit acc;
    logic [3:0] exp_rdy;
    logic [DW-1:0] b;
    for (int i = 0; i < 4; i++)
      if (pq[i].size() == 0 && $urandom_range(99) < newp) push_burst(i, $urandom_range(1, 4));
    for (int i = 0; i < 4; i++) begin
      tv[i] = (pq[i].size() > 0) && ($urandom_range(99) < vp);
      td[i] = (pq[i].size() > 0) ? pq[i][0] : rand_beat(1'b0);
    end
    rdy_in = ($urandom_range(99) < rp);
    @(negedge ACLK);
    // Burst-level rule: owner only while locked, else first valid after last grant.
    have = 1'b0;
    sel = 0;
    if (locked) begin
      sel = owner;
      have = 1'b1;
    end else begin
      for (int k = 1; k <= 4; k++)
        if (!have && tv[(lg + k) % 4]) begin
          sel = (lg + k) % 4;
          have = 1'b1;
        end
    end
    le = !full || rdy_in;
    exp_rdy = (have && le) ? 4'(1 << sel) : 4'b0;
    chk("s_ready", DW'(dr), DW'(exp_rdy));
    chk("m_valid", DW'(m.VALID), DW'(full));
    acc = have && le && tv[sel];
    @(posedge ACLK);
    if (full && rdy_in) full = 1'b0;
    if (acc) begin
      b = pq[sel].pop_front();
      sb.push_back(b);
      full = 1'b1;
      if (b[0]) begin
        locked = 1'b0;
        lg = sel;
      end else if (!locked) begin
        locked = 1'b1;
        owner = sel;
      end
    end
    #1;
  endtask

  // Asynchronous reset pulse in the middle of a cycle; entered at posedge+1.
  task automatic mid_reset();
    #2 ARESETn = 1'b0;
    #1;
    chk("rst_valid", DW'(m.VALID), '0);
    chk("rst_ready", DW'(dr), '0);
    chk("rst_data", m.DATA, '0);
    sb.delete();
    for (int i = 0; i < 4; i++) pq[i].delete();
    full = 1'b0;
    locked = 1'b0;
    lg = 3;
    tv = '0;
    rdy_in = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge ACLK) begin
    if (ARESETn && m.VALID && m.READY) begin
      if (sb.size() == 0) chk("extra_beat", m.DATA, '0);
      else chk("m_data", m.DATA, sb.pop_front());
    end
  end

  initial begin
    logic [DW-1:0] w;
    tv = '0;
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) td[i] = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("init_valid", DW'(m.VALID), '0);
    chk("init_data", m.DATA, '0);
    chk("init_ready", DW'(dr), '0);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;

    // All ports with single beats, no backpressure: 0,1,2,3,0,...
    for (int i = 0; i < 4; i++) begin
      push_burst(i, 1);
      push_burst(i, 1);
    end
    repeat (12) step(100, 100, 0);

    // Port 2 four-beat burst against a constantly valid port 1.
    push_burst(2, 4);
    for (int j = 0; j < 6; j++) push_burst(1, 1);
    repeat (14) step(100, 100, 0);

    // Random traffic with VALID gaps and backpressure.
    repeat (300) step(70, 60, 40);

    // Walking-one and all-ones patterns, all fields bit-exact.
    for (int n = 0; n < DW; n++) begin
      w = '0;
      w[n] = 1'b1;
      pq[n % 4].push_back(w);
    end
    for (int i = 0; i < 4; i++) pq[i].push_back('1);
    repeat (300) step(80, 80, 0);

    // Reset mid-burst on port 3, then port 0 must win first.
    mid_reset();
    push_burst(3, 4);
    repeat (2) step(100, 100, 0);
    mid_reset();
    push_burst(0, 1);
    push_burst(3, 1);
    repeat (4) step(100, 100, 0);

    // More random traffic, including a reset in the middle.
    repeat (150) step(75, 50, 50);
    mid_reset();
    repeat (150) step(60, 70, 50);

    // Drain the output register.
    repeat (5) step(0, 100, 0);
    chk("drain_empty", DW'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
